// File: rtl/ewb_write_buffer_if.sv
// Bus bundle for the eviction write buffer: upstream (L2) request/response side
// and physical-memory side, plus the buffer-empty status.
interface ewb_write_buffer_if;
  logic         mem_read;
  logic         mem_write;
  logic [15:0]  mem_address;
  logic [127:0] mem_wdata;
  logic         mem_resp;
  logic [127:0] mem_rdata;
  logic         pmem_read;
  logic         pmem_write;
  logic [15:0]  pmem_address;
  logic [127:0] pmem_wdata;
  logic         pmem_resp;
  logic [127:0] pmem_rdata;
  logic         ewb_empty;

  modport slave (
    input  mem_read, mem_write, mem_address, mem_wdata, pmem_resp, pmem_rdata,
    output mem_resp, mem_rdata, pmem_read, pmem_write, pmem_address, pmem_wdata, ewb_empty
  );

  modport master (
    output mem_read, mem_write, mem_address, mem_wdata, pmem_resp, pmem_rdata,
    input  mem_resp, mem_rdata, pmem_read, pmem_write, pmem_address, pmem_wdata, ewb_empty
  );
endinterface

// File: rtl/ewb_write_buffer.sv
// Eviction write buffer: coalescing circular FIFO of dirty lines between L2 and
// physical memory, serving read hits from the buffer and draining in the background.
module ewb_write_buffer #(
  parameter int DEPTH = 4
) (
  input logic             clk,
  input logic             reset_n,
  ewb_write_buffer_if.slave bus
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACK   = 2'd1,
    FETCH = 2'd2,
    DRAIN = 2'd3
  } state_t;

  state_t           state_r;
  logic [DEPTH-1:0] valid_r;
  logic [11:0]      tag_r  [DEPTH];
  logic [127:0]     data_r [DEPTH];
  logic [PW-1:0]    head_r;
  logic [PW-1:0]    tail_r;
  logic [CW-1:0]    count_r;
  logic [127:0]     rdata_r;
  logic [15:0]      pmem_addr_r;
  logic [127:0]     pmem_wdata_r;

  logic [11:0]      req_tag_s;
  logic             hit_s;
  logic [PW-1:0]    hit_idx_s;
  logic             full_s;
  logic             unused_addr_bits_s;

  assign req_tag_s          = bus.mem_address[15:4];
  assign unused_addr_bits_s = ^bus.mem_address[3:0];
  assign full_s             = (count_r == CW'(DEPTH));

  // Tag lookup against all valid entries; coalescing keeps tags unique, first match wins.
  always_comb begin
    hit_s     = 1'b0;
    hit_idx_s = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (!hit_s && valid_r[i] && (tag_r[i] == req_tag_s)) begin
        hit_s     = 1'b1;
        hit_idx_s = PW'(i);
      end else begin
        hit_s     = hit_s;
      end
    end
  end

  // Request FSM, FIFO storage and registered datapath.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r      <= IDLE;
      valid_r      <= '0;
      head_r       <= '0;
      tail_r       <= '0;
      count_r      <= '0;
      rdata_r      <= 128'd0;
      pmem_addr_r  <= 16'd0;
      pmem_wdata_r <= 128'd0;
      for (int i = 0; i < DEPTH; i++) begin
        tag_r[i]  <= 12'd0;
        data_r[i] <= 128'd0;
      end
    end else begin
      case (state_r)
        IDLE: begin
          if (bus.mem_write) begin
            if (hit_s) begin
              data_r[hit_idx_s] <= bus.mem_wdata;
              state_r           <= ACK;
            end else if (!full_s) begin
              valid_r[tail_r] <= 1'b1;
              tag_r[tail_r]   <= req_tag_s;
              data_r[tail_r]  <= bus.mem_wdata;
              tail_r          <= tail_r + PW'(1);
              count_r         <= count_r + CW'(1);
              state_r         <= ACK;
            end else begin
              // Full: free the oldest slot; the held write is re-evaluated afterwards.
              pmem_addr_r  <= {tag_r[head_r], 4'h0};
              pmem_wdata_r <= data_r[head_r];
              state_r      <= DRAIN;
            end
          end else if (bus.mem_read) begin
            if (hit_s) begin
              rdata_r <= data_r[hit_idx_s];
              state_r <= ACK;
            end else begin
              pmem_addr_r <= {req_tag_s, 4'h0};
              state_r     <= FETCH;
            end
          end else if (count_r != CW'(0)) begin
            pmem_addr_r  <= {tag_r[head_r], 4'h0};
            pmem_wdata_r <= data_r[head_r];
            state_r      <= DRAIN;
          end else begin
            state_r <= IDLE;
          end
        end
        ACK: begin
          state_r <= IDLE;
        end
        FETCH: begin
          if (bus.pmem_resp) begin
            rdata_r <= bus.pmem_rdata;
            state_r <= ACK;
          end else begin
            state_r <= FETCH;
          end
        end
        DRAIN: begin
          if (bus.pmem_resp) begin
            valid_r[head_r] <= 1'b0;
            head_r          <= head_r + PW'(1);
            count_r         <= count_r - CW'(1);
            state_r         <= IDLE;
          end else begin
            state_r <= DRAIN;
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign bus.mem_resp     = (state_r == ACK);
  assign bus.pmem_read    = (state_r == FETCH);
  assign bus.pmem_write   = (state_r == DRAIN);
  assign bus.mem_rdata    = rdata_r;
  assign bus.pmem_address = pmem_addr_r;
  assign bus.pmem_wdata   = pmem_wdata_r;
  assign bus.ewb_empty    = (count_r == CW'(0));
endmodule

// File: doc/ewb_write_buffer.md
EWB_WRITE_BUFFER -- requirements
Module: ewb_write_buffer

Interface
REQ-001: Parameter DEPTH, default 4, number of dirty-line entries; power of two, at least 2.
REQ-002: clk  input  1  single clock; all state updates on its rising edge.
REQ-003: reset_n  input  1  asynchronous, active-low reset.
REQ-004: mem_read  input  1  upstream (L2) line-read request, held until mem_resp.
REQ-005: mem_write  input  1  upstream evicted-line write request, held until mem_resp.
REQ-006: mem_address  input  16  upstream byte address; line tag = mem_address[15:4] (lc3b_evict_tag).
REQ-007: mem_wdata  input  128  evicted line (lc3b_data).
REQ-008: mem_resp  output  1  one-cycle completion pulse to upstream.
REQ-009: mem_rdata  output  128  registered read data, valid while mem_resp is high.
REQ-010: pmem_read  output  1  physical-memory read request.
REQ-011: pmem_write  output  1  physical-memory write request.
REQ-012: pmem_address  output  16  physical-memory address; bits [3:0] always 0.
REQ-013: pmem_wdata  output  128  line written to physical memory.
REQ-014: pmem_resp  input  1  physical-memory completion pulse.
REQ-015: pmem_rdata  input  128  physical-memory read data, valid with pmem_resp.
REQ-016: ewb_empty  output  1  high when no valid entry is buffered.

Function
REQ-017: Storage: DEPTH entries of {valid, 12-bit tag, 128-bit data} as a circular FIFO with head/tail pointers (log2 DEPTH bits, wrapping DEPTH-1 -> 0) and a count (0..DEPTH).
REQ-018: FSM states: IDLE, ACK, FETCH, DRAIN; one request served at a time.
REQ-019: IDLE, mem_write, tag matches a valid entry: overwrite that entry's data in place (coalesce), count unchanged -> ACK.
REQ-020: IDLE, mem_write, no match, count < DEPTH: enqueue at tail, tail+1, count+1 -> ACK.
REQ-021: IDLE, mem_write, no match, count == DEPTH (full): -> DRAIN; write is retried in IDLE after the drain completes.
REQ-022: IDLE, mem_read, tag matches a valid entry (hit): load mem_rdata from that entry -> ACK; no pmem access.
REQ-023: IDLE, mem_read, miss: -> FETCH.
REQ-024: IDLE, no request, count > 0: -> DRAIN; no request and empty: stay IDLE.
REQ-025: Priority in IDLE: mem_write over mem_read over background drain; mem_read and mem_write both high is treated as mem_write.
REQ-026: ACK: mem_resp = 1 for exactly one cycle, then IDLE.
REQ-027: FETCH: pmem_read = 1, pmem_address = {mem_address[15:4], 4'b0}; on pmem_resp load mem_rdata from pmem_rdata -> ACK.
REQ-028: DRAIN: pmem_write = 1, pmem_address = {head tag, 4'b0}, pmem_wdata = head data; on pmem_resp clear head valid, head+1, count-1 -> IDLE.
REQ-029: pmem_read, pmem_write and mem_resp are decoded from state only; never both pmem_read and pmem_write high.
REQ-030: Minimum latencies: buffered write or read hit gives mem_resp 1 cycle after the request is sampled in IDLE; a read miss gives mem_resp 1 cycle after pmem_resp.
REQ-031: A read whose line is buffered never observes stale physical-memory data.
REQ-032: ewb_empty = (count == 0).

Reset
REQ-033: While reset_n is low, asynchronously: state = IDLE, pointers = 0, count = 0, all valid bits = 0, mem_rdata = 0, mem_resp/pmem_read/pmem_write = 0, ewb_empty = 1.
REQ-034: Reset during DRAIN or FETCH aborts the access immediately; buffered lines are discarded; the late pmem_resp after release is ignored in IDLE.

Verification
REQ-035: Write 0x1230, data A, to an empty buffer -> mem_resp 1 cycle after the request is sampled; count = 1; no pmem activity during the request.
REQ-036: Read 0x1230 after the REQ-035 write -> mem_resp with mem_rdata = A and no pmem_read; then an idle cycle -> DRAIN writes A to 0x1230.
REQ-037: Write 0x1230, data A, then 0x1230, data B -> count stays 1; the later drain writes B only.
REQ-038: Fill DEPTH distinct tags, then a 5th write (DEPTH=4) -> DRAIN writes the oldest line first; the 5th write is acked after pmem_resp plus 2 cycles; pointer wrap is correct.
REQ-039: Read miss 0x4560 with pmem_rdata = C returned after 3 cycles -> pmem_read held for 3 cycles; mem_resp 1 cycle after pmem_resp; mem_rdata = C.
REQ-040: Assert reset_n low mid-DRAIN -> pmem_write drops without a clock edge; after release ewb_empty = 1 and no pmem request is issued.
